// File: rtl/nstack_mem.sv
// nstack_mem: stack storage responder with registered top-of-stack, handshaked peek port and sticky over/underflow flags
// Ports:
//   clock, reset                       clock and asynchronous active-high reset
//   STACK_write_flag/addr/data         controller write port; addr is the current top (0 = empty)
//   STACK_data                         registered top-of-stack word
//   PEEK_req/offset/ready              peek request, entries below top, accept when ready
//   PEEK_valid/data/err/ack            peek response held until ack; data 0 and err 1 below bottom
//   STACK_overflow/underflow           sticky error flags, cleared by ERR_clear
module nstack_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              STACK_write_flag,
  input  logic [ADDR_W-1:0] STACK_write_addr,
  input  logic [DATA_W-1:0] STACK_write_data,
  output logic [DATA_W-1:0] STACK_data,
  input  logic              PEEK_req,
  input  logic [ADDR_W-1:0] PEEK_offset,
  output logic              PEEK_ready,
  output logic              PEEK_valid,
  input  logic              PEEK_ack,
  output logic [DATA_W-1:0] PEEK_data,
  output logic              PEEK_err,
  output logic              STACK_overflow,
  output logic              STACK_underflow,
  input  logic              ERR_clear
);
  localparam int AW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [0:DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] prev_addr, idx;
  logic [AW-1:0] wa, ra;
  logic idx_err, in_range, over, wr_en, of_set, uf_set;
  assign in_range = STACK_write_addr != '0 && STACK_write_addr <= DEPTH_A;
  assign over = STACK_write_addr > DEPTH_A;
  assign wr_en = STACK_write_flag && in_range;
  assign wa = in_range ? STACK_write_addr[AW-1:0] : '0;
  assign ra = idx_err ? '0 : idx[AW-1:0];
  assign of_set = STACK_write_flag && over;
  assign uf_set = prev_addr == '0 && STACK_write_addr == '1;
  assign PEEK_ready = state == IDLE;
  always_ff @(posedge clock)
    if (wr_en) mem[wa] <= STACK_write_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      STACK_data <= '0;
      prev_addr <= '0;
      STACK_overflow <= 1'b0;
      STACK_underflow <= 1'b0;
    end else begin
      STACK_data <= !in_range ? '0 : STACK_write_flag ? STACK_write_data : mem[wa];
      prev_addr <= STACK_write_addr;
      STACK_overflow <= of_set || (STACK_overflow && !ERR_clear);
      STACK_underflow <= uf_set || (STACK_underflow && !ERR_clear);
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE && PEEK_req) ? READ :
              (state == READ) ? RESP :
              (state == RESP && PEEK_valid && PEEK_ack) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx <= '0;
      idx_err <= 1'b0;
      rd_word <= '0;
      PEEK_valid <= 1'b0;
      PEEK_data <= '0;
      PEEK_err <= 1'b0;
    end else begin
      if (state == IDLE && PEEK_req) begin
        idx <= STACK_write_addr - PEEK_offset;
        idx_err <= PEEK_offset >= STACK_write_addr || over;
      end
      if (state == READ)
        rd_word <= (STACK_write_flag && STACK_write_addr == idx) ? STACK_write_data : mem[ra];
      if (state == RESP && !PEEK_valid) begin
        PEEK_valid <= 1'b1;
        PEEK_data <= idx_err ? '0 : rd_word;
        PEEK_err <= idx_err;
      end else if (state == RESP && PEEK_ack) begin
        PEEK_valid <= 1'b0;
        PEEK_data <= '0;
        PEEK_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_nstack_mem.sv
// tb_nstack_mem: randomized scoreboard bench for nstack_mem against a behavioural stack model
module tb_nstack_mem;
  localparam int DEPTH = 1024;
  typedef struct packed {logic [31:0] d; logic e;} pk_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flag = 1'b0, req = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [15:0] addr = '0, off = '0;
  logic [31:0] data = '0;
  logic [31:0] STACK_data, PEEK_data;
  logic PEEK_ready, PEEK_valid, PEEK_err, STACK_overflow, STACK_underflow;
  logic [31:0] mm [0:DEPTH];
  logic [31:0] q_top [$];
  pk_t q_pk [$];
  pk_t cur = '0;
  bit m_ovf = 0, m_unf = 0, busy = 0, rd_pend = 0, p_err = 0, pv = 0;
  logic [15:0] m_prev = '0, p_idx = '0;
  int c = 0, acc = 0;
  int checks = 0, errors = 0;
  nstack_mem dut (
    .clock(clock), .reset(reset),
    .STACK_write_flag(flag), .STACK_write_addr(addr), .STACK_write_data(data),
    .STACK_data(STACK_data),
    .PEEK_req(req), .PEEK_offset(off), .PEEK_ready(PEEK_ready), .PEEK_valid(PEEK_valid),
    .PEEK_ack(ack), .PEEK_data(PEEK_data), .PEEK_err(PEEK_err),
    .STACK_overflow(STACK_overflow), .STACK_underflow(STACK_underflow), .ERR_clear(clr)
  );
  always #5 clock = ~clock;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    int ia, io;
    @(posedge clock);
    ia = int'(addr);
    io = int'(off);
    if (reset) begin
      q_top.delete();
      q_top.push_back('0);
      q_pk.delete();
      m_ovf = 0;
      m_unf = 0;
      m_prev = '0;
      busy = 0;
      rd_pend = 0;
    end else begin
      c++;
      if (flag && ia >= 1 && ia <= DEPTH) mm[ia] = data;
      q_top.push_back((ia == 0 || ia > DEPTH) ? 32'd0 : mm[ia]);
      m_ovf = (flag && ia > DEPTH) ? 1'b1 : clr ? 1'b0 : m_ovf;
      m_unf = (m_prev == 16'd0 && addr == 16'hFFFF) ? 1'b1 : clr ? 1'b0 : m_unf;
      m_prev = addr;
      if (rd_pend) begin
        q_pk.push_back(p_err ? pk_t'{d: 32'd0, e: 1'b1} : pk_t'{d: mm[int'(p_idx)], e: 1'b0});
        rd_pend = 0;
      end
      if (busy) begin
        if (ack && c >= acc + 3) busy = 0;
      end else if (req) begin
        busy = 1;
        acc = c;
        p_idx = addr - off;
        p_err = io >= ia || ia > DEPTH;
        rd_pend = 1;
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (q_top.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL top_queue: got empty expected entry at %0t", $time);
    end else chk("top", STACK_data, q_top.pop_front());
    chk("overflow", 32'(STACK_overflow), 32'(m_ovf));
    chk("underflow", 32'(STACK_underflow), 32'(m_unf));
    chk("ready", 32'(PEEK_ready), 32'(!busy));
    chk("valid", 32'(PEEK_valid), 32'(busy && c >= acc + 2));
    if (PEEK_valid && !pv) begin
      if (q_pk.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL peek_queue: got valid expected no response at %0t", $time);
      end else cur = q_pk.pop_front();
    end
    if (PEEK_valid) begin
      chk("peek_data", PEEK_data, cur.d);
      chk("peek_err", 32'(PEEK_err), 32'(cur.e));
    end else begin
      chk("peek_data_idle", PEEK_data, 32'd0);
      chk("peek_err_idle", 32'(PEEK_err), 32'd0);
    end
    pv = PEEK_valid;
  end
  task automatic step();
    @(negedge clock);
    #1;
  endtask
  task automatic drive(logic f, logic [15:0] a, logic [31:0] d);
    flag = f;
    addr = a;
    data = d;
    step();
  endtask
  task automatic peek(logic [15:0] o, int hold);
    int n = 0;
    req = 1'b1;
    off = o;
    step();
    req = 1'b0;
    while (!PEEK_valid && n < 10) begin
      step();
      n++;
    end
    if (!PEEK_valid) begin
      checks++;
      errors++;
      $display("FAIL peek_timeout: got no valid expected valid within 10 cycles");
    end
    repeat (hold) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    reset = 1'b0;
    for (int a = 1; a <= DEPTH; a++) drive(1'b1, 16'(a), $urandom);
    drive(1'b0, 16'd0, '0);
    drive(1'b1, 16'd1, 32'hA);
    drive(1'b1, 16'd2, 32'hB);
    drive(1'b1, 16'd3, 32'hC);
    drive(1'b0, 16'd3, '0);
    drive(1'b0, 16'd2, '0);
    drive(1'b0, 16'd3, '0);
    peek(16'd2, 5);
    peek(16'd3, 2);
    peek(16'd0, 0);
    drive(1'b0, 16'd0, '0);
    drive(1'b0, 16'hFFFF, '0);
    drive(1'b0, 16'hFFFF, '0);
    clr = 1'b1;
    drive(1'b0, 16'd0, '0);
    clr = 1'b0;
    drive(1'b0, 16'd0, '0);
    drive(1'b1, 16'(DEPTH + 1), $urandom);
    drive(1'b0, 16'(DEPTH), '0);
    clr = 1'b1;
    drive(1'b0, 16'(DEPTH), '0);
    clr = 1'b0;
    flag = 1'b0;
    addr = 16'd3;
    req = 1'b1;
    off = 16'd1;
    step();
    req = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    drive(1'b0, 16'd0, '0);
    drive(1'b0, 16'd3, '0);
    drive(1'b0, 16'd3, '0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      flag = 1'($urandom_range(0, 1));
      addr = r == 0 ? 16'd0 : r == 1 ? 16'hFFFF : r == 2 ? 16'(DEPTH + 1 + int'($urandom_range(0, 5)))
             : 16'($urandom_range(1, DEPTH));
      data = $urandom;
      req = $urandom_range(0, 2) == 0;
      off = $urandom_range(0, 1) == 1 ? 16'($urandom_range(0, 8)) : 16'($urandom_range(0, DEPTH + 10));
      ack = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 15) == 0;
      step();
    end
    flag = 1'b0;
    req = 1'b0;
    clr = 1'b0;
    ack = 1'b1;
    repeat (6) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
